switch_conditioner: RTL and testbench

Input-side companion to the LED/switch decoder logic: takes the four raw active-low push-button lines, synchronises and debounces them, and presents a clean active-high pressed vector plus single-cycle press/release event strobes. It sits between the board pins and any state-decoding or LED-driving logic, so downstream `case` decoders see one stable update per physical press instead of bounce.

---
 rtl/switch_conditioner_if.sv | 32 +++
 rtl/switch_conditioner.sv | 123 ++++++++++++
 tb/tb_switch_conditioner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/switch_conditioner_if.sv
// switch_conditioner_if
//   Pin-side and event-side signals of the push-button conditioner.
//   master: board/stimulus side. It drives the raw pins and observes the events.
//   slave : the conditioner. It takes the raw pins and drives the events.
//   switch1..switch4 : raw pins, active-low, asynchronous to clk
//   state            : debounced pressed vector {switch1..switch4}, active-high
//   press            : one-cycle strobe per bit on debounced 0->1
//   released         : one-cycle strobe per bit on debounced 1->0
//                      (named "released" because "release" is a reserved word)
//   changed          : one-cycle strobe, OR of press and released bits
//   long_press       : one-cycle strobe per bit when the hold threshold is reached
interface switch_conditioner_if;
  logic       switch1;
  logic       switch2;
  logic       switch3;
  logic       switch4;
  logic [3:0] state;
  logic [3:0] press;
  logic [3:0] released;
  logic       changed;
  logic [3:0] long_press;

  modport master (
    output switch1, switch2, switch3, switch4,
    input  state, press, released, changed, long_press
  );

  modport slave (
    input  switch1, switch2, switch3, switch4,
    output state, press, released, changed, long_press
  );
endinterface

// File: rtl/switch_conditioner.sv
// switch_conditioner
//   Synchronises and debounces four active-low push-button pins. It presents a
//   clean active-high pressed vector plus one-cycle press/release/changed
//   strobes. The optional long-press detector is enabled by defining the macro
//   SWITCH_LONGPRESS_EN. Without that macro, long_press is tied to zero.
//   Parameters:
//     DEBOUNCE_CYCLES  : consecutive disagreeing cycles before a new state is
//                        accepted (>= 1)
//     LONGPRESS_CYCLES : cycles a debounced press is held before long_press
//                        (>= 1; used only with SWITCH_LONGPRESS_EN)
//   Ports:
//     clk : system clock
//     rst : asynchronous active-high reset
//     bus : switch_conditioner_if.slave (pins in, debounced state/strobes out)
module switch_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES  = 120000,
  parameter int unsigned LONGPRESS_CYCLES = 12000000
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_conditioner_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONGPRESS_CYCLES < 1) begin : g_bad_longpress
    $error("LONGPRESS_CYCLES must be at least 1");
  end

  logic [3:0]    pin_n;
  logic [3:0]    sync_meta;
  logic [3:0]    sync;
  logic [3:0]    state_r;
  logic [3:0]    press_r;
  logic [3:0]    release_r;
  logic          changed_r;
  logic [3:0]    toggle;
  logic [CW-1:0] db_cnt [4];

  assign pin_n = {bus.switch1, bus.switch2, bus.switch3, bus.switch4};

  // The bit toggles on the edge where the counter already holds DB_LAST and
  // sync still disagrees. This gives exactly DEBOUNCE_CYCLES disagreeing cycles.
  always_comb begin
    toggle = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      toggle[i] = (sync[i] != state_r[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
      state_r   <= '0;
      press_r   <= '0;
      release_r <= '0;
      changed_r <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_meta <= ~pin_n;
      sync      <= sync_meta;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync[i] == state_r[i] || toggle[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      state_r   <= state_r ^ toggle;
      press_r   <= toggle & ~state_r;
      release_r <= toggle & state_r;
      changed_r <= |toggle;
    end
  end

`ifdef SWITCH_LONGPRESS_EN
  localparam int unsigned LW = $clog2(LONGPRESS_CYCLES + 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LONGPRESS_CYCLES);
  localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_CYCLES - 1);

  logic [LW-1:0] hold_cnt [4];
  logic [3:0]    long_r;

  // The counter saturates at LP_MAX, so the strobe fires once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_r <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!state_r[i]) begin
          hold_cnt[i] <= '0;
          long_r[i]   <= 1'b0;
        end else if (hold_cnt[i] != LP_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          long_r[i]   <= (hold_cnt[i] == LP_LAST);
        end else begin
          long_r[i]   <= 1'b0;
        end
      end
    end
  end

  assign bus.long_press = long_r;
`else
  assign bus.long_press = '0;
`endif

  assign bus.state    = state_r;
  assign bus.press    = press_r;
  assign bus.released = release_r;
  assign bus.changed  = changed_r;

endmodule

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  switch_conditioner_if sw_if ();

  switch_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .LONGPRESS_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sw_if)
  );

  always #5 clk = ~clk;

  // Compare {state, press, released, changed, long_press}.
  task automatic chk(input string tag, input logic [3:0] st, input logic [3:0] pr,
                     input logic [3:0] rl, input logic ch, input logic [3:0] lp);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {sw_if.state, sw_if.press, sw_if.released, sw_if.changed, sw_if.long_press};
    exp = {st, pr, rl, ch, lp};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b (state,press,rel,chg,lp)", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] lp_exp;
    sw_if.switch1 = 1'b1;
    sw_if.switch2 = 1'b1;
    sw_if.switch3 = 1'b1;
    sw_if.switch4 = 1'b1;

    // 1: reset state, then idle
    #2;
    chk("reset_async", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end

    // 2: switch1 press and release latency
    sw_if.switch1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("s1_press_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    tick();
    chk("s1_press_edge6", 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    tick();
    chk("s1_press_after", 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    sw_if.switch1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("s1_rel_wait", 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    tick();
    chk("s1_rel_edge6", 4'b0000, 4'b0000, 4'b1000, 1'b1, 4'b0000);
    tick();
    chk("s1_rel_after", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // 3: short glitch and bouncing on switch2
    sw_if.switch2 = 1'b0;
    tick(); tick(); tick();
    sw_if.switch2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s2_glitch", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) sw_if.switch2 = ~sw_if.switch2;
      tick();
      chk("s2_bounce", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    sw_if.switch2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s2_settle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end

    // 4: simultaneous switch3 + switch4
    sw_if.switch3 = 1'b0;
    sw_if.switch4 = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    chk("s34_press", 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0000);
    tick();
    chk("s34_press_after", 4'b0011, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    sw_if.switch3 = 1'b1;
    sw_if.switch4 = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    chk("s34_release", 4'b0000, 4'b0000, 4'b0011, 1'b1, 4'b0000);
    tick();
    chk("s34_rel_after", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // 5: hold switch4 past the long-press threshold
    sw_if.switch4 = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    chk("s4_press", 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000);
    for (int k = 1; k <= 30; k++) begin
      tick();
      lp_exp = 4'b0000;
`ifdef SWITCH_LONGPRESS_EN
      if (k == 10) lp_exp = 4'b0001;
`endif
      chk("s4_hold", 4'b0001, 4'b0000, 4'b0000, 1'b0, lp_exp);
    end
    sw_if.switch4 = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    chk("s4_release", 4'b0000, 4'b0000, 4'b0001, 1'b1, 4'b0000);

    // 6: reset mid-debounce and while pressed
    sw_if.switch1 = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    #2 rst = 1'b1;
    #1 chk("rst_mid_debounce", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rst1_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    tick();
    chk("rst1_press", 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    tick();
    chk("rst1_held", 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    #2 rst = 1'b1;
    #1 chk("rst_while_pressed", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    #2 rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rst2_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    tick();
    chk("rst2_press", 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    tick();
    chk("rst2_held", 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
